// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage issue controller for the pipelined multiply/divide unit.
// It decodes the MDU command held in E and drives the MDU start/opcode request.
// It stalls D while an MDU-dependent instruction has to wait for the unit.
// It steers HI/LO onto the E result path for mfhi/mflo.
// A shadow busy model is kept, and a sticky error is flagged when that model
// disagrees with the MDU, or when a command reaches E while the MDU is busy.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   Req             exception/interrupt taken; squashes the E instruction
//   e_valid         E holds a real instruction
//   e_cmd[3:0]      E MDU command (1 mult .. 8 mflo, else none)
//   d_uses_mdu      D instruction is an MDU command
//   mdu_busy        MDU busy output
//   mdu_hi/mdu_lo   MDU HI/LO registers
//   start           MDU start request (combinational)
//   mdu_op[3:0]     MDU opcode while start is high, else 0 (combinational)
//   stall_d         freeze F/D and insert a bubble into E (combinational)
//   e_result[31:0]  HI for mfhi, LO for mflo, else 0 (combinational)
//   e_result_sel    e_result replaces the ALU result (combinational)
//   proto_err       sticky protocol error flag (registered)
module mdu_issue_ctrl #(
   parameter int unsigned MUL_CYCLES = 5,
   parameter int unsigned DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        e_valid,
   input  logic [3:0]  e_cmd,
   input  logic        d_uses_mdu,
   input  logic        mdu_busy,
   input  logic [31:0] mdu_hi,
   input  logic [31:0] mdu_lo,
   output logic        start,
   output logic [3:0]  mdu_op,
   output logic        stall_d,
   output logic [31:0] e_result,
   output logic        e_result_sel,
   output logic        proto_err
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_proto_err, w_proto_err_nxt;

   logic w_cmd_is_req;
   logic w_req_ok;
   logic w_issue;
   logic w_issue_err;
   logic w_shadow_busy;

   // Commands 1..6 need the MDU; 7/8 only read HI/LO.
   assign w_cmd_is_req  = (e_cmd >= 4'd1) && (e_cmd <= 4'd6);
   assign w_req_ok      = e_valid && !Req && w_cmd_is_req;
   assign w_issue       = w_req_ok && (r_state == S_IDLE);
   // A request while busy means the D stall failed to hold it back.
   assign w_issue_err   = w_req_ok && (r_state != S_IDLE);
   assign w_shadow_busy = (r_state != S_IDLE);

   // State, counter and sticky error registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_proto_err <= w_proto_err_nxt;
      end
   end

   // Next-state, counter and error tracking
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_proto_err_nxt = r_proto_err;

      case (r_state)
         S_IDLE: begin
            if (w_issue) begin
               if ((e_cmd == 4'd1) || (e_cmd == 4'd2)) begin
                  w_state_nxt = S_MUL;
                  w_cnt_nxt   = CNT_W'(MUL_CYCLES - 1);
               end else if ((e_cmd == 4'd3) || (e_cmd == 4'd4)) begin
                  w_state_nxt = S_DIV;
                  w_cnt_nxt   = CNT_W'(DIV_CYCLES - 1);
               end
            end
         end
         S_MUL, S_DIV: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase

      // The MDU only raises busy on the edge after start, so skip the start cycle.
      if (!w_issue && (w_shadow_busy != mdu_busy)) begin
         w_proto_err_nxt = 1'b1;
      end
      if (w_issue_err) begin
         w_proto_err_nxt = 1'b1;
      end
   end

   // Combinational request, stall and HI/LO steering
   always_comb begin
      start        = w_issue;
      mdu_op       = 4'd0;
      stall_d      = d_uses_mdu && (w_issue || w_shadow_busy || mdu_busy);
      e_result     = 32'd0;
      e_result_sel = 1'b0;

      if (w_issue) begin
         mdu_op = e_cmd;
      end
      if (e_cmd == 4'd7) begin
         e_result     = mdu_hi;
         e_result_sel = e_valid;
      end else if (e_cmd == 4'd8) begin
         e_result     = mdu_lo;
         e_result_sel = e_valid;
      end
   end

   assign proto_err = r_proto_err;

endmodule

// File: doc/mdu_issue_ctrl.md
# mdu_issue_ctrl

E-stage issue controller for the pipelined multiply/divide unit (MDU). It decodes the MDU command carried by the instruction in E, drives the MDU's `start`/`MDUop` request, and stalls D while an MDU-dependent instruction must wait. It also steers HI/LO onto the E result path for mfhi/mflo and keeps a shadow busy model that flags any divergence from the MDU's `busy` output.

## Interface
Parameters:
- MUL_CYCLES, 5, cycles `busy` stays high after a mult/multu start edge
- DIV_CYCLES, 10, cycles `busy` stays high after a div/divu start edge

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- Req  in  1  exception/interrupt taken this cycle; squashes E instruction
- e_valid  in  1  E stage holds a real (non-bubble) instruction
- e_cmd  in  4  E MDU command: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9–15 none
- d_uses_mdu  in  1  D-stage instruction has e_cmd in 1..8
- mdu_busy  in  1  MDU busy output
- mdu_hi  in  32  MDU HI register
- mdu_lo  in  32  MDU LO register
- start  out  1  MDU start request (combinational)
- mdu_op  out  4  MDU opcode: 1 mult, 2 multu, 3 div, 4 divu, 5 write HI, 6 write LO, else 0
- stall_d  out  1  freeze F/D, insert bubble into E (combinational)
- e_result  out  32  mdu_hi for cmd 7, mdu_lo for cmd 8, else 0
- e_result_sel  out  1  e_result replaces ALU result (cmd 7/8 and e_valid)
- proto_err  out  1  sticky: shadow busy disagreed with mdu_busy or issue while busy

## Operation
- issue = e_valid && !Req && e_cmd in 1..6 && state==IDLE; start = issue; mdu_op = issue ? e_cmd : 0.
- e_cmd in 1..6 with e_valid, !Req, state!=IDLE: start not asserted, proto_err set next edge (D stall should have prevented it).
- FSM states IDLE, MUL, DIV; 4-bit down-counter cnt.
  - IDLE: issue with cmd 1/2 -> MUL, cnt=MUL_CYCLES-1; cmd 3/4 -> DIV, cnt=DIV_CYCLES-1; cmd 5/6 -> stay IDLE.
  - MUL/DIV: cnt!=0 -> cnt-1; cnt==0 -> IDLE.
- shadow_busy = (state!=IDLE); from the edge after start, it matches mdu_busy cycle-for-cycle.
- Compare every cycle except the start cycle: shadow_busy != mdu_busy -> proto_err <= 1. proto_err clears only on reset.
- stall_d = d_uses_mdu && (start || shadow_busy || mdu_busy).
- Req: suppresses start in the same cycle. Does not cancel an operation already in MUL/DIV; counting and stall continue.
- e_result/e_result_sel: combinational. Not gated by Req, since writeback squash belongs to the pipeline.

## Timing
- Reset (sync): state=IDLE, cnt=0, proto_err=0. With inputs idle, all outputs are 0 the cycle after reset.
- Start cycle T (start=1): MDU samples on edge T. Shadow busy is high in cycles T+1..T+MUL_CYCLES (mult) or T+1..T+DIV_CYCLES (div), then low.
- A D-stage MDU instruction is stalled from cycle T through the last busy cycle, and issues to E the cycle after busy drops.
- mthi/mtlo: start for 1 cycle, no busy. A following mfhi in D does not stall past T; it sees the new value in E at T+1.
- Back-to-back mult then mfhi: mfhi reaches E exactly one cycle after shadow_busy falls, reading the final HI.
- Reset mid-operation: FSM to IDLE next edge regardless of cnt; proto_err cleared.
- Simultaneous Req and issue: start=0, state unchanged, no proto_err.

## Test plan
- Reset, then e_valid=1, e_cmd=1 at cycle 0 -> start=1/mdu_op=1 at cycle 0. Shadow busy high cycles 1–5. With d_uses_mdu=1, stall_d high cycles 0–5, low at 6. proto_err=0.
- e_cmd=4 (divu) issue -> shadow busy 10 cycles. mflo in D is released when busy drops. e_result equals mdu_lo (e.g. 7/2 -> LO=3) with e_result_sel=1.
- mthi with mdu_opA=0x12345678, then mfhi next cycle -> no stall_d beyond the issue cycle. e_result=0x12345678.
- Req=1 in the same cycle as e_cmd=3 -> start=0, state stays IDLE, stall_d driven only by mdu_busy.
- Force mdu_busy low 2 cycles early during mult -> proto_err=1 next edge and stays 1 until reset.
- Reset asserted at cnt=6 of a div -> state IDLE, stall_d=0, proto_err=0 after the edge. A new mult issues normally the following cycle.
